vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
Upstream timing stage for the pixel generators such as the pipe/bird renderer. It divides the system clock into a pixel-rate tick and runs the horizontal and vertical counters over a full VGA frame (640x480 @ 60 Hz at a 25 MHz pixel rate by default). It drives registered hsync/vsync, a video_on window, line and frame strobes, and a frame counter. The rgb generators consume h_counter/v_counter; game logic uses the strobes to pace animation.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=1; 100 MHz -> 25 MHz)
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, active level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  system clock
clear  in  1  synchronous reset, active-high
pix_tick  out  1  one-clk pulse marking the first system cycle of each new pixel
h_counter  out  10  horizontal position, 0..H_TOTAL-1
v_counter  out  10  vertical position, 0..V_TOTAL-1
hsync  out  1  horizontal sync, level per SYNC_ACTIVE
vsync  out  1  vertical sync, level per SYNC_ACTIVE
video_on  out  1  high while (h_counter, v_counter) is inside the visible area
line_start  out  1  one-clk pulse after h_counter wraps to 0
frame_start  out  1  one-clk pulse after both counters wrap to (0,0)
frame_count  out  16  completed-frame count, wraps 65535->0

Behaviour:
- Interface: one clock, clk. Reset clear is synchronous and active-high; it is sampled only on the rising edge of clk.
- Derived values:
  - H_TOTAL = sum of H_*; default 800.
  - V_TOTAL = sum of V_*; default 525.
  - H_TOTAL and V_TOTAL must each be <=1024.
- Reset: while clear is sampled high, on each edge:
  - divider := 0, h_counter := 0, v_counter := 0, frame_count := 0.
  - hsync and vsync := ~SYNC_ACTIVE.
  - video_on, pix_tick, line_start, frame_start := 0.
  - Clear mid-frame takes effect on the next edge, with no completion of the line or frame. No strobe or frame_count increment results from it.
- Divider:
  - Counts 0..CLK_DIV-1. An "advance" occurs on the edge where divider == CLK_DIV-1; divider then wraps to 0.
  - pix_tick is registered and high exactly in the clk cycle following each advance. Period is CLK_DIV clks, duty 1/CLK_DIV.
  - With CLK_DIV=1, an advance occurs every edge and pix_tick stays high continuously after the first post-reset edge.
- Counters (update only on an advance):
  - h_counter := h_counter+1; at H_TOTAL-1 it wraps to 0.
  - On that wrap, v_counter := v_counter+1; at V_TOTAL-1 it wraps to 0.
  - Counters never exceed TOTAL-1.
- Sync and window outputs:
  - Registered, computed from the counter values being loaded on the same edge, so they are cycle-aligned with h_counter/v_counter. No extra latency.
  - hsync is active when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (default 656..751).
  - vsync is active when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (default 490..491).
  - video_on = (h < H_VISIBLE) && (v < V_VISIBLE).
  - Post-reset: in the first cycle after clear deasserts, video_on is still 0 with counters at (0,0). It becomes 1 on the first non-clear edge.
- Strobes:
  - line_start is high for the one clk following an advance in which h wrapped to 0.
  - frame_start is high for the one clk following an advance in which both counters wrapped to (0,0). line_start is also high in that cycle.
  - Neither strobe fires on reset exit. The first frame_start comes after one full frame: H_TOTAL*V_TOTAL*CLK_DIV clks, 1,680,000 by default.
- frame_count increments on the same edge that asserts frame_start. It is unsigned 16-bit and wraps from 65535 to 0.

Test Plan:
- Reset: hold clear 5 clks mid-frame at (300,200) -> next edge counters = 0, hsync = vsync = 1, video_on = 0, frame_count = 0, all strobes 0; after release, video_on = 1 one clk later.
- Cadence, CLK_DIV=4 -> pix_tick high 1 of every 4 clks; h_counter steps 0,1,2,... once per 4 clks, each step aligned with a pix_tick cycle.
- Line wrap: h = 799 -> next advance gives h = 0, v += 1, line_start = 1 for exactly 1 clk. hsync is low for h = 656..751 (96 pixels = 384 clks) and high at 655 and 752.
- Frame wrap: (799,524) -> (0,0), frame_start and line_start both high 1 clk, frame_count 0->1. vsync is low only on v = 490, 491. video_on = 0 at h = 640 and at v = 480.
- frame_count wrap: force 65535, run to next frame boundary -> frame_count = 0 and frame_start = 1.
- CLK_DIV=1 build -> counters advance every clk, pix_tick constantly 1 after reset exit, frame_start period exactly 420,000 clks.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, horizontal/vertical counters,
// registered sync/window outputs, line/frame strobes and a frame counter.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        clear,
    output logic        pix_tick,
    output logic [9:0]  h_counter,
    output logic [9:0]  v_counter,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_S = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_E = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int unsigned V_SYNC_S = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_E = V_VISIBLE + V_FRONT + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_q, video_d;
    logic             pix_q;
    logic             line_q, line_d;
    logic             frame_q, frame_d;
    logic [15:0]      frame_count_q;
    logic             advance;
    logic             h_wrap;
    logic             v_wrap;

    // Next-state counters; sync/window outputs are decoded from the values
    // being loaded so they stay aligned with h_counter/v_counter.
    always_comb begin
        advance = (div_q == DIV_W'(CLK_DIV - 1));
        div_d   = advance ? '0 : div_q + 1'b1;
        h_wrap  = (h_q == 10'(H_TOTAL - 1));
        v_wrap  = (v_q == 10'(V_TOTAL - 1));
        h_d     = h_q;
        v_d     = v_q;
        if (advance) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 1'b1;
            end
        end
        line_d  = advance && h_wrap;
        frame_d = line_d && v_wrap;
        hsync_d = ({1'b0, h_d} >= 11'(H_SYNC_S) && {1'b0, h_d} < 11'(H_SYNC_E))
                  ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = ({1'b0, v_d} >= 11'(V_SYNC_S) && {1'b0, v_d} < 11'(V_SYNC_E))
                  ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        video_d = ({1'b0, h_d} < 11'(H_VISIBLE)) && ({1'b0, v_d} < 11'(V_VISIBLE));
    end

    // State and registered outputs, synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            video_q       <= 1'b0;
            pix_q         <= 1'b0;
            line_q        <= 1'b0;
            frame_q       <= 1'b0;
            frame_count_q <= '0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            pix_q   <= advance;
            line_q  <= line_d;
            frame_q <= frame_d;
            if (frame_d) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign pix_tick    = pix_q;
    assign h_counter   = h_q;
    assign v_counter   = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a closed-form timing model (position
// derived from the number of post-reset edges) pushes expected outputs on
// every rising edge; they are popped and compared on the falling edge.
module tb_vga_sync_gen;

    localparam int unsigned HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int unsigned VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int unsigned HT = HV + HF + HS + HB;   // 30
    localparam int unsigned VT = VV + VF + VS + VB;   // 17
    localparam int unsigned FRAME_PIX = HT * VT;      // 510
    localparam logic        SA = 1'b0;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        vo;
        logic        pt;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    logic        d4_pt, d4_hs, d4_vs, d4_vo, d4_ls, d4_fs;
    logic [9:0]  d4_h, d4_v;
    logic [15:0] d4_fc;
    logic        d1_pt, d1_hs, d1_vs, d1_vo, d1_ls, d1_fs;
    logic [9:0]  d1_h, d1_v;
    logic [15:0] d1_fc;

    vga_sync_gen #(
        .CLK_DIV(4), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE(SA)
    ) dut (
        .clk(clk), .clear(clear), .pix_tick(d4_pt), .h_counter(d4_h), .v_counter(d4_v),
        .hsync(d4_hs), .vsync(d4_vs), .video_on(d4_vo), .line_start(d4_ls),
        .frame_start(d4_fs), .frame_count(d4_fc)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE(SA)
    ) dut1 (
        .clk(clk), .clear(clear), .pix_tick(d1_pt), .h_counter(d1_h), .v_counter(d1_v),
        .hsync(d1_hs), .vsync(d1_vs), .video_on(d1_vo), .line_start(d1_ls),
        .frame_start(d1_fs), .frame_count(d1_fc)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs after k non-clear edges since the last clear.
    function automatic exp_t model(input int unsigned k, input int unsigned div,
                                   input logic [15:0] fbase);
        exp_t e;
        int unsigned adv, h, v;
        adv  = k / div;
        h    = adv % HT;
        v    = (adv / HT) % VT;
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.pt = (k > 0) && (k % div == 0);
        e.ls = e.pt && (h == 0);
        e.fs = e.ls && (v == 0);
        e.vo = (k > 0) && (h < HV) && (v < VV);
        e.hs = (h >= HV + HF && h < HV + HF + HS) ? SA : ~SA;
        e.vs = (v >= VV + VF && v < VV + VF + VS) ? SA : ~SA;
        e.fc = fbase + 16'(adv / FRAME_PIX);
        return e;
    endfunction

    exp_t q4[$];
    exp_t q1[$];
    int unsigned k4 = 0, k1 = 0;
    logic [15:0] fb4 = '0, fb1 = '0;
    logic fs_rearm = 1'b1;

    // Model: advance the edge counts and push expectations on every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (clear) begin
                k4 = 0; k1 = 0; fb4 = '0; fb1 = '0; fs_rearm = 1'b1;
            end else begin
                k4++; k1++;
            end
            q4.push_back(model(k4, 4, fb4));
            q1.push_back(model(k1, 1, fb1));
        end
    end

    // Scoreboard compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check("d4.h",  32'(d4_h),  32'(e.h));
                check("d4.v",  32'(d4_v),  32'(e.v));
                check("d4.hs", 32'(d4_hs), 32'(e.hs));
                check("d4.vs", 32'(d4_vs), 32'(e.vs));
                check("d4.vo", 32'(d4_vo), 32'(e.vo));
                check("d4.pt", 32'(d4_pt), 32'(e.pt));
                check("d4.ls", 32'(d4_ls), 32'(e.ls));
                check("d4.fs", 32'(d4_fs), 32'(e.fs));
                check("d4.fc", 32'(d4_fc), 32'(e.fc));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("d1.h",  32'(d1_h),  32'(e.h));
                check("d1.v",  32'(d1_v),  32'(e.v));
                check("d1.hs", 32'(d1_hs), 32'(e.hs));
                check("d1.vs", 32'(d1_vs), 32'(e.vs));
                check("d1.vo", 32'(d1_vo), 32'(e.vo));
                check("d1.pt", 32'(d1_pt), 32'(e.pt));
                check("d1.ls", 32'(d1_ls), 32'(e.ls));
                check("d1.fs", 32'(d1_fs), 32'(e.fs));
                check("d1.fc", 32'(d1_fc), 32'(e.fc));
            end
        end
    end

    // frame_start period on the CLK_DIV=1 instance and hsync pulse width on the CLK_DIV=4 one.
    initial begin
        int unsigned cyc = 0, last = 0, hs_run = 0;
        logic have_last = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (fs_rearm) begin
                have_last = 1'b0;
                fs_rearm  = 1'b0;
            end
            if (d1_fs === 1'b1) begin
                if (have_last) check("d1.fs_period", cyc - last, FRAME_PIX);
                last      = cyc;
                have_last = 1'b1;
            end
            if (d4_hs === SA) begin
                hs_run++;
            end else begin
                if (hs_run != 0) check("d4.hsync_width", hs_run, HS * 4);
                hs_run = 0;
            end
        end
    end

    task automatic wait_hv(input logic [9:0] h, input logic [9:0] v);
        int unsigned n = 0;
        while (!(d4_h == h && d4_v == v) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("wait_hv_in_time", 32'(n < 5000), 32'd1);
    endtask

    initial begin
        int unsigned ticks, n, frames;
        repeat (3) @(negedge clk);
        clear = 1'b0;

        // Run through two full frames.
        n = 0;
        while (d4_fc != 16'd2 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("two_frames_in_time", 32'(n < 6000), 32'd1);

        // pix_tick duty on the CLK_DIV=4 instance.
        ticks = 0;
        repeat (400) begin
            @(negedge clk);
            if (d4_pt === 1'b1) ticks++;
        end
        check("d4.pix_tick_duty", ticks, 100);

        // Clear mid-frame for 5 clocks.
        wait_hv(10'd10, 10'd5);
        clear = 1'b1;
        repeat (5) @(negedge clk);
        clear = 1'b0;
        repeat (300) @(negedge clk);

        // Preload frame_count to 65535 and run to the next frame boundary.
        wait_hv(10'd5, 10'd3);
        #2;
        frames = (k4 / 4) / FRAME_PIX;
        fb4 = 16'(32'hFFFF - frames);
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clk);
        #2;
        release dut.frame_count_q;
        n = 0;
        while (d4_fs !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("fc_wrap_in_time", 32'(n < 3000), 32'd1);
        check("fc_wrap_value", 32'(d4_fc), 32'd0);
        check("fc_wrap_fs", 32'(d4_fs), 32'd1);

        repeat (100) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
